jstk_input_conditioner: RTL and testbench

JSTK_INPUT_CONDITIONER -- requirements
Module: jstk_input_conditioner

---
 rtl/jstk_input_conditioner.sv | 113 +++++++++++
 tb/tb_jstk_input_conditioner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/jstk_input_conditioner.sv
// PmodJSTK input conditioner: strobe sync/capture, dead-zone steering, stale watchdog, fire FSM.
// Define JSTK_AUTOFIRE_EN to let a held button re-fire after every cooldown.
module jstk_input_conditioner #(
  parameter logic [9:0] DEAD_LO        = 10'd400,
  parameter logic [9:0] DEAD_HI        = 10'd624,
  parameter int         COOLDOWN_TICKS = 8,
  parameter int         STALE_TICKS    = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Sample_Strobe,
  input  logic [39:0] Jstk_Data,
  input  logic        Tick,
  output logic [9:0]  X_Pos,
  output logic [1:0]  Move_Dir,
  output logic        Fire_Pulse,
  output logic        Fire_Ready,
  output logic        Sample_Valid
);
  localparam int CW = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;
  localparam int SW = (STALE_TICKS > 0) ? $clog2(STALE_TICKS + 1) : 1;
  localparam logic [CW-1:0] CD_LOAD    = CW'(COOLDOWN_TICKS);
  localparam logic [SW-1:0] STALE_MAX  = SW'(STALE_TICKS);
  localparam logic [SW-1:0] STALE_LAST = SW'(STALE_TICKS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, FIRE = 2'd2, COOLDOWN = 2'd3} state_t;

  state_t        state, state_nxt;
  logic [2:0]    strobe_pipe;
  logic          capture;
  logic          btn;
  logic          btn_new;
  logic [SW-1:0] stale_cnt;
  logic          stale_hit;
  logic [CW-1:0] cd_cnt;
  logic          unused_bits;

  assign unused_bits = ^{Jstk_Data[39:24], Jstk_Data[15:10], Jstk_Data[7:2], Jstk_Data[0]};

  // [1:0] is the synchronizer, [2] the edge-detect history
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) strobe_pipe <= '0;
    else          strobe_pipe <= {strobe_pipe[1:0], Sample_Strobe};

  assign capture   = strobe_pipe[1] & ~strobe_pipe[2];
  assign btn_new   = Jstk_Data[1];
  assign stale_hit = Tick & ~capture & (stale_cnt == STALE_LAST);

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      X_Pos        <= 10'd512;
      btn          <= 1'b0;
      Sample_Valid <= 1'b0;
      stale_cnt    <= '0;
    end else if (capture) begin
      X_Pos        <= {Jstk_Data[9:8], Jstk_Data[23:16]};
      btn          <= btn_new;
      Sample_Valid <= 1'b1;
      stale_cnt    <= '0;
    end else if (Tick && stale_cnt != STALE_MAX) begin
      stale_cnt <= stale_cnt + SW'(1);
      if (stale_hit) begin
        Sample_Valid <= 1'b0;
        btn          <= 1'b0;
      end
    end

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n)                      Move_Dir <= 2'b00;
    else if (stale_hit || !Sample_Valid) Move_Dir <= 2'b00;
    else if (X_Pos < DEAD_LO)          Move_Dir <= 2'b01;
    else if (X_Pos > DEAD_HI)          Move_Dir <= 2'b10;
    else                               Move_Dir <= 2'b00;

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;

  // Release back to ARMED is immediate once the count hits 0; an autofire
  // re-shot waits for one more Tick so the shot period is COOLDOWN_TICKS+1.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (!btn) state_nxt = ARMED;
      ARMED:    if (capture && !btn && btn_new) state_nxt = FIRE;
      FIRE:     state_nxt = COOLDOWN;
      COOLDOWN: if (cd_cnt == '0) begin
        if (!btn) state_nxt = ARMED;
`ifdef JSTK_AUTOFIRE_EN
        else if (Tick && Sample_Valid && !stale_hit) state_nxt = FIRE;
`else
        else state_nxt = IDLE;
`endif
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n)                                      cd_cnt <= '0;
    else if (state == FIRE)                            cd_cnt <= CD_LOAD;
    else if (state == COOLDOWN && Tick && cd_cnt != '0) cd_cnt <= cd_cnt - CW'(1);

  always_comb begin
    Fire_Pulse = 1'b0;
    Fire_Ready = 1'b0;
    case (state)
      FIRE:    Fire_Pulse = 1'b1;
      ARMED:   Fire_Ready = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_jstk_input_conditioner.sv
// Directed bench for jstk_input_conditioner: captured X positions go through a scoreboard
// queue; a monitor logs every Fire_Pulse with the Tick count at which it appeared.
module tb_jstk_input_conditioner;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Sample_Strobe = 1'b0;
  logic [39:0] Jstk_Data = '0;
  logic        Tick = 1'b0;
  logic [9:0]  X_Pos;
  logic [1:0]  Move_Dir;
  logic        Fire_Pulse, Fire_Ready, Sample_Valid;

  int total = 0;
  int bad = 0;
  int tick_cnt = 0;
  int pulse_cnt = 0;
  int invalid_fire = 0;
  int wide_fire = 0;
  logic fp_prev = 1'b0;
  int pulse_ticks[$];
  logic [9:0] exp_q[$];
  logic [1:0] prev_dir = 2'b00;

  jstk_input_conditioner dut (
    .Clk(Clk), .Reset_n(Reset_n), .Sample_Strobe(Sample_Strobe), .Jstk_Data(Jstk_Data),
    .Tick(Tick), .X_Pos(X_Pos), .Move_Dir(Move_Dir), .Fire_Pulse(Fire_Pulse),
    .Fire_Ready(Fire_Ready), .Sample_Valid(Sample_Valid)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    #2;
    if (Fire_Pulse) begin
      pulse_cnt++;
      pulse_ticks.push_back(tick_cnt);
      if (!Sample_Valid) invalid_fire++;
      if (fp_prev) wide_fire++;
    end
    fp_prev = Fire_Pulse;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] dir_of(input logic [9:0] x);
    if (x < 10'd400) return 2'b01;
    if (x > 10'd624) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk); Tick = 1'b1; tick_cnt++;
    @(negedge Clk); Tick = 1'b0;
  endtask

  // Returns on the negedge right after the capturing posedge
  task automatic capture(input logic [9:0] x, input logic b, input bit with_tick);
    Sample_Strobe = 1'b0;
    repeat (2) @(negedge Clk);
    Jstk_Data = {$urandom, 8'($urandom)};
    Jstk_Data[9:8] = x[9:8];
    Jstk_Data[23:16] = x[7:0];
    Jstk_Data[1] = b;
    Sample_Strobe = 1'b1;
    exp_q.push_back(x);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      if (with_tick) begin
        Tick = (i == 1);
        if (i == 1) tick_cnt++;
      end
    end
  endtask

  task automatic check_capture();
    logic [9:0] x;
    logic [1:0] d;
    chk("sb_depth", exp_q.size(), 1);
    if (exp_q.size() == 0) return;
    x = exp_q.pop_front();
    chk("x_pos", X_Pos, x);
    chk("valid_on_capture", Sample_Valid, 1);
    chk("dir_hold", Move_Dir, prev_dir);
    @(negedge Clk);
    d = dir_of(x);
    chk("move_dir", Move_Dir, d);
    prev_dir = d;
  endtask

  initial begin
    logic [9:0] dz[4];
    int base, base_idx, n_exp;
    dz = '{10'd399, 10'd400, 10'd624, 10'd625};

    // reset values
    repeat (2) @(negedge Clk);
    chk("rst_xpos", X_Pos, 10'd512);
    chk("rst_dir", Move_Dir, 0);
    chk("rst_fire", Fire_Pulse, 0);
    chk("rst_ready", Fire_Ready, 0);
    chk("rst_valid", Sample_Valid, 0);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("ready_after_rst", Fire_Ready, 1);

    // dead-zone edges
    for (int i = 0; i < 4; i++) begin
      capture(dz[i], 1'b0, 1'b0);
      check_capture();
    end

    // single shot
    base = pulse_cnt;
    capture(10'd500, 1'b1, 1'b0);
    chk("shot_pulse", Fire_Pulse, 1);
    chk("shot_ready_low", Fire_Ready, 0);
    check_capture();
    chk("shot_pulse_width", Fire_Pulse, 0);
    capture(10'd500, 1'b0, 1'b0);
    check_capture();
    repeat (7) tick();
    chk("cooldown_7", Fire_Ready, 0);
    tick();
    @(negedge Clk);
    chk("rearm_8", Fire_Ready, 1);
    chk("shot_count", pulse_cnt - base, 1);

    // held button for 30 Ticks, refreshed every 5 Ticks
    base = pulse_cnt;
    base_idx = pulse_ticks.size();
    for (int i = 0; i < 30; i++) begin
      if (i % 5 == 4) begin
        capture(10'd500, 1'b1, 1'b0);
        check_capture();
      end
      tick();
    end
`ifdef JSTK_AUTOFIRE_EN
    n_exp = 3;
`else
    n_exp = 1;
`endif
    chk("held_pulses", pulse_cnt - base, n_exp);
    for (int k = base_idx + 1; k < pulse_ticks.size(); k++)
      chk("autofire_spacing", pulse_ticks[k] - pulse_ticks[k-1], 9);
    capture(10'd500, 1'b0, 1'b0);
    check_capture();
    repeat (10) tick();
    chk("held_release_ready", Fire_Ready, 1);

    // staleness and capture+Tick collision at count 15
    capture(10'd100, 1'b0, 1'b0);
    check_capture();
    repeat (15) tick();
    chk("fresh_at_15", Sample_Valid, 1);
    capture(10'd100, 1'b0, 1'b1);
    chk("collide_valid", Sample_Valid, 1);
    chk("collide_cnt", dut.stale_cnt, 0);
    check_capture();
    repeat (15) tick();
    chk("fresh_again_15", Sample_Valid, 1);
    chk("dir_before_stale", Move_Dir, 1);
    tick();
    chk("stale_valid", Sample_Valid, 0);
    chk("stale_dir", Move_Dir, 0);
    prev_dir = 2'b00;
    capture(10'd100, 1'b0, 1'b0);
    check_capture();

    // reset in the middle of COOLDOWN
    capture(10'd500, 1'b1, 1'b0);
    chk("pre_rst_pulse", Fire_Pulse, 1);
    check_capture();
    repeat (3) tick();
    Sample_Strobe = 1'b0;
    #3 Reset_n = 1'b0;
    #1;
    chk("mid_rst_xpos", X_Pos, 10'd512);
    chk("mid_rst_dir", Move_Dir, 0);
    chk("mid_rst_fire", Fire_Pulse, 0);
    chk("mid_rst_ready", Fire_Ready, 0);
    chk("mid_rst_valid", Sample_Valid, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    prev_dir = 2'b00;
    base = pulse_cnt;
    repeat (20) @(negedge Clk);
    chk("no_pulse_after_rst", pulse_cnt - base, 0);
    chk("ready_after_mid_rst", Fire_Ready, 1);
    capture(10'd500, 1'b1, 1'b0);
    check_capture();
    chk("new_press_fires", pulse_cnt - base, 1);

    chk("fire_while_invalid", invalid_fire, 0);
    chk("wide_pulses", wide_fire, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
